// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI master arbiter.
// Index width covers the maximum of 8 requesters.
package spi_arb_pkg;

   localparam int unsigned NReqDefault  = 4;
   localparam int unsigned SsWDefault   = 24;
   localparam int unsigned StartTimeout = 4;
   localparam int unsigned IdxW         = 3;
   localparam int unsigned TmoW         = 2;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StWaitBusy,
      StRun,
      StDone
   } state_e;

endpackage

// File: rtl/spi_arb_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping modulo N_REQ.
module rr_pick
   import spi_arb_pkg::*;
#(
   parameter int unsigned N_REQ = NReqDefault
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IdxW-1:0]  ptr_i,
   output logic [IdxW-1:0]  idx_o,
   output logic             any_o
);

   logic [IdxW:0] cand;

   always_comb begin
      idx_o = '0;
      any_o = 1'b0;
      cand  = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         cand = {1'b0, ptr_i} + (IdxW + 1)'(i);
         // ptr_i is always below N_REQ, so one subtraction wraps
         if (cand >= (IdxW + 1)'(N_REQ)) begin
            cand = cand - (IdxW + 1)'(N_REQ);
         end
         if (!any_o && (((req_i >> cand) & N_REQ'(1)) != '0)) begin
            any_o = 1'b1;
            idx_o = cand[IdxW-1:0];
         end
      end
   end

endmodule

// File: rtl/spi_arb.sv
// Round-robin arbiter sharing one SPI master between N_REQ requesters; checks
// the received byte count and times out a master that never goes busy.
module spi_arb
   import spi_arb_pkg::*;
#(
   parameter int unsigned N_REQ = NReqDefault,
   parameter int unsigned SS_W  = SsWDefault
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ-1:0][SS_W-1:0] req_ss_mask,
   input  logic [N_REQ-1:0][7:0]      req_len,
   input  logic [N_REQ-1:0][7:0]      req_tx_data,
   output logic [N_REQ-1:0]           req_read,
   output logic [N_REQ-1:0]           req_valid,
   output logic [7:0]                 req_rx_data,
   output logic [N_REQ-1:0]           gnt,
   output logic [N_REQ-1:0]           done,
   output logic                       err,
   output logic                       m_start,
   output logic [SS_W-1:0]            m_ss_mask,
   output logic [7:0]                 m_trans_len,
   input  logic                       m_read,
   output logic [7:0]                 m_tx_data,
   input  logic                       m_valid,
   input  logic [7:0]                 m_rx_data,
   input  logic                       m_busy
);

   state_e          state_q, state_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
   logic [8:0]      cnt_q, cnt_d;
   logic [TmoW-1:0] tmo_q, tmo_d;
   logic            tmo_err_q, tmo_err_d;
   logic [SS_W-1:0] m_ss_mask_q, m_ss_mask_d;
   logic [7:0]      m_trans_len_q, m_trans_len_d;

   logic [IdxW-1:0] win_idx;
   logic            win_any;
   logic [SS_W-1:0] sel_mask;
   logic [7:0]      sel_len;
   logic            active;

   rr_pick #(
      .N_REQ (N_REQ)
   ) u_rr_pick (
      .req_i (req),
      .ptr_i (rr_ptr_q),
      .idx_o (win_idx),
      .any_o (win_any)
   );

   assign active = (state_q != StIdle);

   // Muxes decode the index by comparison to avoid selects wider than N_REQ needs
   always_comb begin
      sel_mask  = '0;
      sel_len   = '0;
      m_tx_data = '0;
      gnt       = '0;
      for (int unsigned j = 0; j < N_REQ; j++) begin
         if (win_idx == IdxW'(j)) begin
            sel_mask = req_ss_mask[j];
            sel_len  = req_len[j];
         end
         if (idx_q == IdxW'(j)) begin
            m_tx_data = req_tx_data[j];
            gnt[j]    = active;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      rr_ptr_d      = rr_ptr_q;
      cnt_d         = cnt_q;
      tmo_d         = tmo_q;
      tmo_err_d     = tmo_err_q;
      m_ss_mask_d   = m_ss_mask_q;
      m_trans_len_d = m_trans_len_q;
      unique case (state_q)
         StIdle: begin
            if (win_any && !m_busy) begin
               idx_d         = win_idx;
               m_ss_mask_d   = sel_mask;
               m_trans_len_d = sel_len;
               state_d       = StStart;
            end
         end
         StStart: begin
            cnt_d     = '0;
            tmo_d     = '0;
            tmo_err_d = 1'b0;
            state_d   = StWaitBusy;
         end
         StWaitBusy: begin
            if (m_valid) cnt_d = cnt_q + 9'd1;
            if (m_busy) begin
               state_d = StRun;
            end else if (tmo_q == TmoW'(StartTimeout - 1)) begin
               tmo_err_d = 1'b1;
               state_d   = StDone;
            end else begin
               tmo_d = tmo_q + TmoW'(1);
            end
         end
         StRun: begin
            if (m_valid) cnt_d = cnt_q + 9'd1;
            if (!m_busy) state_d = StDone;
         end
         StDone: begin
            if (m_valid) cnt_d = cnt_q + 9'd1;
            rr_ptr_d = (idx_q == IdxW'(N_REQ - 1)) ? '0 : idx_q + IdxW'(1);
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         idx_q         <= '0;
         rr_ptr_q      <= '0;
         cnt_q         <= '0;
         tmo_q         <= '0;
         tmo_err_q     <= 1'b0;
         m_ss_mask_q   <= '0;
         m_trans_len_q <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         rr_ptr_q      <= rr_ptr_d;
         cnt_q         <= cnt_d;
         tmo_q         <= tmo_d;
         tmo_err_q     <= tmo_err_d;
         m_ss_mask_q   <= m_ss_mask_d;
         m_trans_len_q <= m_trans_len_d;
      end
   end

   assign m_start     = (state_q == StStart);
   assign done        = (state_q == StDone) ? gnt : '0;
   assign err         = (state_q == StDone) &&
                        (tmo_err_q || (cnt_q != ({1'b0, m_trans_len_q} + 9'd1)));
   assign m_ss_mask   = m_ss_mask_q;
   assign m_trans_len = m_trans_len_q;
   assign req_read    = gnt & {N_REQ{m_read}};
   assign req_valid   = gnt & {N_REQ{m_valid}};
   assign req_rx_data = m_rx_data;

endmodule

// File: tb/tb_spi_arb.sv
// Directed bench for spi_arb with a small behavioural SPI master model.
module tb_spi_arb;

   localparam int unsigned NR = 4;
   localparam int unsigned SW = 24;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [NR-1:0]           req;
   logic [NR-1:0][SW-1:0]   req_ss_mask;
   logic [NR-1:0][7:0]      req_len;
   logic [NR-1:0][7:0]      req_tx_data;
   logic [NR-1:0]           req_read, req_valid, gnt, done;
   logic [7:0]              req_rx_data;
   logic                    err, m_start;
   logic [SW-1:0]           m_ss_mask;
   logic [7:0]              m_trans_len, m_tx_data, m_rx_data;
   logic                    m_read, m_valid, m_busy;
   logic                    mst_busy, mst_valid, ext_busy, ext_valid;
   int                      mst_mode;

   int pass_cnt = 0;
   int total_cnt = 0;

   bit            obs_to;
   int            obs_sc, obs_dc, obs_nstart, obs_nval;
   logic [NR-1:0] obs_gnt, obs_vmask, obs_done, obs_rd;
   logic [SW-1:0] obs_ss;
   logic [7:0]    obs_len, obs_tx;
   logic          obs_err, obs_err_early;

   always #5 clk = ~clk;

   assign m_busy  = mst_busy | ext_busy;
   assign m_valid = mst_valid | ext_valid;

   spi_arb #(
      .N_REQ (NR),
      .SS_W  (SW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .req_ss_mask (req_ss_mask),
      .req_len     (req_len),
      .req_tx_data (req_tx_data),
      .req_read    (req_read),
      .req_valid   (req_valid),
      .req_rx_data (req_rx_data),
      .gnt         (gnt),
      .done        (done),
      .err         (err),
      .m_start     (m_start),
      .m_ss_mask   (m_ss_mask),
      .m_trans_len (m_trans_len),
      .m_read      (m_read),
      .m_tx_data   (m_tx_data),
      .m_valid     (m_valid),
      .m_rx_data   (m_rx_data),
      .m_busy      (m_busy)
   );

   // Master model: mode 0 normal, 1 never busy, 2 one byte short
   initial begin
      int nb;
      mst_busy  = 1'b0;
      mst_valid = 1'b0;
      m_read    = 1'b0;
      m_rx_data = 8'h00;
      forever begin
         @(posedge clk); #1;
         if (rst_n && m_start) begin
            nb = int'(m_trans_len) + 1;
            if (mst_mode == 2) nb = nb - 1;
            m_read = 1'b1;
            @(posedge clk); #1;
            m_read = 1'b0;
            if (mst_mode != 1) begin
               mst_busy = 1'b1;
               for (int k = 0; k < nb && rst_n; k++) begin
                  @(posedge clk); #1;
                  mst_valid = 1'b1;
                  m_rx_data = 8'hA0 + 8'(k);
               end
               @(posedge clk); #1;
               mst_valid = 1'b0;
               mst_busy  = 1'b0;
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk); #2;
   endtask

   // Collects one transfer from m_start to done; no comparisons here
   task automatic observe(input int budget, input bit drop);
      obs_to = 1'b1; obs_nstart = 0; obs_nval = 0; obs_vmask = '0; obs_err_early = 1'b0;
      obs_sc = -1; obs_dc = -1; obs_gnt = '0; obs_done = '0; obs_err = 1'b0; obs_rd = '0;
      obs_ss = '0; obs_len = '0; obs_tx = '0;
      for (int c = 0; c < budget; c++) begin
         tick();
         if (m_start) begin
            obs_nstart++;
            if (obs_sc < 0) begin
               obs_sc = c; obs_gnt = gnt; obs_ss = m_ss_mask; obs_len = m_trans_len;
               obs_tx = m_tx_data; obs_rd = req_read;
               if (drop) req = '0;
            end
         end
         obs_nval += $countones(req_valid);
         obs_vmask |= req_valid;
         if (done != '0) begin
            obs_done = done; obs_err = err; obs_dc = c; obs_to = 1'b0;
            break;
         end
         if (err) obs_err_early = 1'b1;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      tick(); tick();
      total_cnt++; if (gnt !== 4'b0) $display("FAIL reset_gnt: got %b want 0000", gnt); else pass_cnt++;
      total_cnt++; if (done !== 4'b0) $display("FAIL reset_done: got %b want 0000", done); else pass_cnt++;
      total_cnt++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else pass_cnt++;
      total_cnt++; if (m_start !== 1'b0) $display("FAIL reset_start: got %b want 0", m_start); else pass_cnt++;
      total_cnt++; if (m_ss_mask !== 24'h0) $display("FAIL reset_mask: got %h want 000000", m_ss_mask); else pass_cnt++;
      total_cnt++; if (m_trans_len !== 8'h0) $display("FAIL reset_len: got %h want 00", m_trans_len); else pass_cnt++;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_round_robin;
      int exp_order [5] = '{0, 1, 2, 3, 0};
      logic [NR-1:0] exp_g;
      for (int i = 0; i < 4; i++) begin
         req_len[i] = 8'h00;
         req_ss_mask[i] = 24'h000001 << i;
      end
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         exp_g = 4'b0001 << exp_order[k];
         observe(40, 1'b0);
         total_cnt++; if (obs_to !== 1'b0) $display("FAIL rr%0d_timeout: got no done want done", k); else pass_cnt++;
         total_cnt++; if (obs_gnt !== exp_g) $display("FAIL rr%0d_gnt: got %b want %b", k, obs_gnt, exp_g); else pass_cnt++;
         total_cnt++; if (obs_ss !== (24'h000001 << exp_order[k])) $display("FAIL rr%0d_mask: got %h want %h", k, obs_ss, 24'h000001 << exp_order[k]); else pass_cnt++;
         total_cnt++; if (obs_done !== exp_g) $display("FAIL rr%0d_done: got %b want %b", k, obs_done, exp_g); else pass_cnt++;
         total_cnt++; if (obs_sc !== ((k == 0) ? 0 : 1)) $display("FAIL rr%0d_gap: got %0d want %0d", k, obs_sc, (k == 0) ? 0 : 1); else pass_cnt++;
         total_cnt++; if ((obs_err | obs_err_early) !== 1'b0) $display("FAIL rr%0d_err: got 1 want 0", k); else pass_cnt++;
      end
      req = '0;
      tick();
   endtask

   task automatic test_single;
      req_len[0] = 8'h02;
      req_ss_mask[0] = 24'h000001;
      req = 4'b0001;
      observe(40, 1'b0);
      total_cnt++; if (obs_to !== 1'b0) $display("FAIL single_timeout: got no done want done"); else pass_cnt++;
      total_cnt++; if (obs_nstart !== 1) $display("FAIL single_nstart: got %0d want 1", obs_nstart); else pass_cnt++;
      total_cnt++; if (obs_gnt !== 4'b0001) $display("FAIL single_gnt: got %b want 0001", obs_gnt); else pass_cnt++;
      total_cnt++; if (obs_ss !== 24'h000001) $display("FAIL single_mask: got %h want 000001", obs_ss); else pass_cnt++;
      total_cnt++; if (obs_len !== 8'h02) $display("FAIL single_len: got %h want 02", obs_len); else pass_cnt++;
      total_cnt++; if (obs_tx !== 8'h10) $display("FAIL single_txdata: got %h want 10", obs_tx); else pass_cnt++;
      total_cnt++; if (obs_rd !== 4'b0001) $display("FAIL single_read: got %b want 0001", obs_rd); else pass_cnt++;
      total_cnt++; if (obs_nval !== 3) $display("FAIL single_nvalid: got %0d want 3", obs_nval); else pass_cnt++;
      total_cnt++; if (obs_vmask !== 4'b0001) $display("FAIL single_vmask: got %b want 0001", obs_vmask); else pass_cnt++;
      total_cnt++; if (obs_done !== 4'b0001) $display("FAIL single_done: got %b want 0001", obs_done); else pass_cnt++;
      total_cnt++; if ((obs_err | obs_err_early) !== 1'b0) $display("FAIL single_err: got 1 want 0"); else pass_cnt++;
      total_cnt++; if (obs_dc - obs_sc !== 6) $display("FAIL single_latency: got %0d want 6", obs_dc - obs_sc); else pass_cnt++;
      req = '0;
      tick();
   endtask

   task automatic test_ignore_valid;
      ext_valid = 1'b1;
      #1;
      total_cnt++; if (req_valid !== 4'b0) $display("FAIL idle_valid: got %b want 0000", req_valid); else pass_cnt++;
      tick();
      ext_valid = 1'b0;
   endtask

   task automatic test_drop_req;
      req_len[0] = 8'h01;
      req = 4'b0001;
      observe(40, 1'b1);
      total_cnt++; if (obs_done !== 4'b0001) $display("FAIL drop_done: got %b want 0001", obs_done); else pass_cnt++;
      total_cnt++; if ((obs_err | obs_err_early) !== 1'b0) $display("FAIL drop_err: got 1 want 0"); else pass_cnt++;
      total_cnt++; if (obs_nval !== 2) $display("FAIL drop_nvalid: got %0d want 2", obs_nval); else pass_cnt++;
      tick();
   endtask

   task automatic test_busy_hold;
      bit bad = 1'b0;
      ext_busy = 1'b1;
      req_len[2] = 8'h01;
      req = 4'b0100;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (m_start || gnt != '0) bad = 1'b1;
      end
      total_cnt++; if (bad !== 1'b0) $display("FAIL busy_hold_start: got start want none"); else pass_cnt++;
      ext_busy = 1'b0;
      observe(40, 1'b0);
      total_cnt++; if (obs_sc !== 0) $display("FAIL busy_hold_gap: got %0d want 0", obs_sc); else pass_cnt++;
      total_cnt++; if (obs_gnt !== 4'b0100) $display("FAIL busy_hold_gnt: got %b want 0100", obs_gnt); else pass_cnt++;
      total_cnt++; if (obs_done !== 4'b0100) $display("FAIL busy_hold_done: got %b want 0100", obs_done); else pass_cnt++;
      total_cnt++; if (obs_err !== 1'b0) $display("FAIL busy_hold_err: got %b want 0", obs_err); else pass_cnt++;
      req = '0;
      tick();
   endtask

   task automatic test_timeout;
      mst_mode = 1;
      req_len[3] = 8'h00;
      req = 4'b1000;
      observe(40, 1'b0);
      total_cnt++; if (obs_done !== 4'b1000) $display("FAIL tmo_done: got %b want 1000", obs_done); else pass_cnt++;
      total_cnt++; if (obs_err !== 1'b1) $display("FAIL tmo_err: got %b want 1", obs_err); else pass_cnt++;
      total_cnt++; if (obs_dc - obs_sc !== 5) $display("FAIL tmo_latency: got %0d want 5", obs_dc - obs_sc); else pass_cnt++;
      total_cnt++; if (obs_err_early !== 1'b0) $display("FAIL tmo_err_early: got 1 want 0"); else pass_cnt++;
      req = '0;
      tick();
      mst_mode = 0;
   endtask

   task automatic test_short_count;
      mst_mode = 2;
      req_len[1] = 8'h02;
      req = 4'b0010;
      observe(40, 1'b0);
      total_cnt++; if (obs_nval !== 2) $display("FAIL short_nvalid: got %0d want 2", obs_nval); else pass_cnt++;
      total_cnt++; if (obs_done !== 4'b0010) $display("FAIL short_done: got %b want 0010", obs_done); else pass_cnt++;
      total_cnt++; if (obs_err !== 1'b1) $display("FAIL short_err: got %b want 1", obs_err); else pass_cnt++;
      total_cnt++; if (obs_err_early !== 1'b0) $display("FAIL short_err_early: got 1 want 0"); else pass_cnt++;
      req = '0;
      tick();
      mst_mode = 0;
   endtask

   task automatic test_reset_mid;
      bit seen = 1'b0;
      req_len[3] = 8'h0A;
      req = 4'b1000;
      for (int c = 0; c < 20 && !seen; c++) begin
         tick();
         if (m_start) seen = 1'b1;
      end
      total_cnt++; if (seen !== 1'b1) $display("FAIL rstmid_start: got none want start"); else pass_cnt++;
      tick(); tick(); tick();
      total_cnt++; if (gnt !== 4'b1000) $display("FAIL rstmid_gnt_run: got %b want 1000", gnt); else pass_cnt++;
      rst_n = 1'b0;
      #1;
      total_cnt++; if (gnt !== 4'b0000) $display("FAIL rstmid_gnt_async: got %b want 0000", gnt); else pass_cnt++;
      total_cnt++; if (m_start !== 1'b0) $display("FAIL rstmid_start_async: got %b want 0", m_start); else pass_cnt++;
      req = '0;
      tick(); tick(); tick(); tick();
      req_len[1] = 8'h00;
      req_len[3] = 8'h00;
      req = 4'b1010;
      rst_n = 1'b1;
      observe(40, 1'b0);
      total_cnt++; if (obs_gnt !== 4'b0010) $display("FAIL rstmid_regrant: got %b want 0010", obs_gnt); else pass_cnt++;
      total_cnt++; if (obs_done !== 4'b0010) $display("FAIL rstmid_done: got %b want 0010", obs_done); else pass_cnt++;
      req = '0;
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      req = '0;
      ext_busy = 1'b0;
      ext_valid = 1'b0;
      mst_mode = 0;
      for (int i = 0; i < 4; i++) begin
         req_ss_mask[i] = '0;
         req_len[i]     = '0;
         req_tx_data[i] = 8'h10 + 8'(i);
      end
      test_reset();
      test_round_robin();
      test_single();
      test_ignore_valid();
      test_drop_req();
      test_busy_hold();
      test_timeout();
      test_short_count();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
